// File: rtl/restoring_divider_if.sv
// Start/done handshake bundle for the restoring divider: request operands in, results and status out.
interface restoring_divider_if #(
  parameter int unsigned WIDTH = 16
);
  logic             START;
  logic [WIDTH-1:0] DIVIDEND;
  logic [WIDTH-1:0] DIVISOR;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] QUOTIENT;
  logic [WIDTH-1:0] REMAINDER;
  logic             DIVZERO;

  modport master (
    output START, DIVIDEND, DIVISOR,
    input  BUSY, DONE, QUOTIENT, REMAINDER, DIVZERO
  );

  modport slave (
    input  START, DIVIDEND, DIVISOR,
    output BUSY, DONE, QUOTIENT, REMAINDER, DIVZERO
  );
endinterface

// File: rtl/restoring_divider.sv
// Unsigned restoring divider, one quotient bit per clock; divide-by-zero short-circuits to FIN.
// Each step trial-subtracts via A + ~B + 1, so a carry-out of 1 means the divisor fits.
module restoring_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                MasterClock,
  input  logic                Reset,
  restoring_divider_if.slave  bus
);

  localparam int unsigned NW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           r_state,   w_state_nxt;
  logic [WIDTH:0]   r_r,       w_r_nxt;
  logic [WIDTH-1:0] r_s,       w_s_nxt;
  logic [WIDTH-1:0] r_d,       w_d_nxt;
  logic [NW-1:0]    r_n,       w_n_nxt;
  logic [WIDTH-1:0] r_quot,    w_quot_nxt;
  logic [WIDTH-1:0] r_rem,     w_rem_nxt;
  logic             r_divzero, w_divzero_nxt;
  logic             r_busy,    w_busy_nxt;
  logic             r_done,    w_done_nxt;

  logic [WIDTH:0]   w_rs;
  logic [WIDTH+1:0] w_sum;
  logic [WIDTH:0]   w_t;
  logic             w_c;

  // Trial subtraction of the shifted partial remainder against the latched divisor
  always_comb begin
    w_rs  = {r_r[WIDTH-1:0], r_s[WIDTH-1]};
    w_sum = {1'b0, w_rs} + {1'b0, ~{1'b0, r_d}} + (WIDTH+2)'(1);
    w_c   = w_sum[WIDTH+1];
    w_t   = w_sum[WIDTH:0];
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_r_nxt       = r_r;
    w_s_nxt       = r_s;
    w_d_nxt       = r_d;
    w_n_nxt       = r_n;
    w_quot_nxt    = r_quot;
    w_rem_nxt     = r_rem;
    w_divzero_nxt = r_divzero;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.START) begin
          if (bus.DIVISOR != '0) begin
            w_r_nxt       = '0;
            w_s_nxt       = bus.DIVIDEND;
            w_d_nxt       = bus.DIVISOR;
            w_n_nxt       = '0;
            w_divzero_nxt = 1'b0;
            w_busy_nxt    = 1'b1;
            w_state_nxt   = RUN;
          end else begin
            w_quot_nxt    = '1;
            w_rem_nxt     = bus.DIVIDEND;
            w_divzero_nxt = 1'b1;
            w_done_nxt    = 1'b1;
            w_state_nxt   = FIN;
          end
        end
      end

      RUN: begin
        w_r_nxt = w_c ? w_t : w_rs;
        w_s_nxt = {r_s[WIDTH-2:0], w_c};
        w_n_nxt = r_n + NW'(1);
        // Final iteration publishes the results on the same edge
        if (r_n == NW'(WIDTH - 1)) begin
          w_quot_nxt  = {r_s[WIDTH-2:0], w_c};
          w_rem_nxt   = w_c ? w_t[WIDTH-1:0] : w_rs[WIDTH-1:0];
          w_done_nxt  = 1'b1;
          w_state_nxt = FIN;
        end else begin
          w_busy_nxt  = 1'b1;
        end
      end

      FIN: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge MasterClock) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_r       <= '0;
      r_s       <= '0;
      r_d       <= '0;
      r_n       <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_divzero <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_r       <= w_r_nxt;
      r_s       <= w_s_nxt;
      r_d       <= w_d_nxt;
      r_n       <= w_n_nxt;
      r_quot    <= w_quot_nxt;
      r_rem     <= w_rem_nxt;
      r_divzero <= w_divzero_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign bus.BUSY      = r_busy;
  assign bus.DONE      = r_done;
  assign bus.QUOTIENT  = r_quot;
  assign bus.REMAINDER = r_rem;
  assign bus.DIVZERO   = r_divzero;

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider: driver pushes expected results, monitor checks each DONE.
module tb_restoring_divider;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           cyc;
    int           busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   done_seen = 0;
  int   busy_cnt = 0;
  int   last_done = -1;
  bit   sweep = 1'b0;
  exp_t sb[$];

  restoring_divider_if #(.WIDTH(W)) bus ();

  restoring_divider #(.WIDTH(W)) dut (
    .MasterClock (clk),
    .Reset       (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero convention
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
    exp_t e;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; e.cyc = acc; e.busy = 0;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0; e.cyc = acc + int'(W); e.busy = int'(W);
    end
    return e;
  endfunction

  // Monitor: pops one expectation per DONE pulse
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (bus.BUSY) busy_cnt++;
      if (bus.DONE) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("quotient",  longint'(bus.QUOTIENT),  longint'(e.q));
          chk("remainder", longint'(bus.REMAINDER), longint'(e.r));
          chk("divzero",   longint'(bus.DIVZERO),   longint'(e.dz));
          chk("done_cycle", cyc, e.cyc);
          chk("busy_cycles", busy_cnt, e.busy);
          if (sweep && last_done >= 0) chk("done_spacing", cyc - last_done, int'(W) + 2);
        end
        last_done = cyc;
        busy_cnt  = 0;
        done_seen++;
      end
    end
  end

  // Present a request in an IDLE cycle; returns just after the accepting edge
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    @(negedge clk);
    bus.START = 1'b1; bus.DIVIDEND = a; bus.DIVISOR = b;
    @(posedge clk);
    #1;
    sb.push_back(model(a, b, cyc));
    if (!hold) begin
      bus.START = 1'b0;
      bus.DIVIDEND = $urandom(); bus.DIVISOR = $urandom();
    end
  endtask

  task automatic wait_done(input int budget);
    int start = done_seen;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (done_seen != start) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic div(input logic [W-1:0] a, input logic [W-1:0] b);
    issue(a, b, 1'b0);
    wait_done(int'(W) + 10);
  endtask

  initial begin
    logic [W-1:0] a, b;
    int sel;
    bus.START = 1'b0; bus.DIVIDEND = '0; bus.DIVISOR = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",    longint'(bus.BUSY), 0);
    chk("rst_done",    longint'(bus.DONE), 0);
    chk("rst_divzero", longint'(bus.DIVZERO), 0);
    chk("rst_quot",    longint'(bus.QUOTIENT), 0);
    chk("rst_rem",     longint'(bus.REMAINDER), 0);
    rst = 1'b0;

    div(16'd100, 16'd7);
    div(16'hFFFF, 16'h0001);
    div(16'd5, 16'd9);
    div(16'hFFFF, 16'hFFFF);
    div(16'h1234, 16'h0000);
    div(16'd10, 16'd3);

    // Second START while busy must be dropped, not queued
    issue(16'd1000, 16'd3, 1'b0);
    repeat (3) @(negedge clk);
    bus.START = 1'b1; bus.DIVIDEND = 16'd50; bus.DIVISOR = 16'd5;
    @(negedge clk);
    bus.START = 1'b0;
    wait_done(int'(W) + 10);
    repeat (int'(W) + 4) @(negedge clk);

    // Reset mid-run abandons the division
    issue(16'd1000, 16'd3, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("abort_busy", longint'(bus.BUSY), 0);
    chk("abort_done", longint'(bus.DONE), 0);
    chk("abort_quot", longint'(bus.QUOTIENT), 0);
    chk("abort_rem",  longint'(bus.REMAINDER), 0);
    rst = 1'b0;
    repeat (int'(W) + 6) @(negedge clk);
    div(16'd9, 16'd2);

    // Back-to-back sweep with START held high
    sweep = 1'b1;
    last_done = -1;
    for (int i = 0; i < 1000; i++) begin
      sel = int'($urandom_range(0, 7));
      a = W'($urandom());
      b = W'($urandom());
      if (sel == 0) a = '0;
      else if (sel == 1) begin a = W'($urandom_range(0, 255)); b = W'($urandom_range(256, 65535)); end
      else if (sel == 2) b = W'($urandom_range(1, 15));
      if (b == '0) b = W'(1);
      issue(a, b, 1'b1);
      repeat (int'(W) + 1) @(posedge clk);
    end
    @(negedge clk);
    bus.START = 1'b0;
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    chk("drained", sb.size(), 0);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
